// File: rtl/prim_max_tree_pipe.sv
// Pipelined, flow-controlled max/min reduction tree with per-beat mode and threshold.
// A register stage follows every RegEvery tree levels; each stage collapses bubbles independently.
module prim_max_tree_pipe #(
  parameter int NumSrc   = 32,
  parameter int Width    = 8,
  parameter int RegEvery = 1,
  localparam int SrcWidth = $clog2(NumSrc)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [NumSrc*Width-1:0] values_i,
  input  logic [NumSrc-1:0]       valid_i,
  input  logic                    min_mode_i,
  input  logic [Width-1:0]        threshold_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [Width-1:0]        max_value_o,
  output logic [SrcWidth-1:0]     max_idx_o,
  output logic                    max_valid_o
);

  localparam int NumLevels = $clog2(NumSrc);
  localparam int NumStages = (NumLevels + RegEvery - 1) / RegEvery;
  localparam int NumLeaves = 1 << NumLevels;
  localparam int NumNodes  = 2 * NumLeaves;

  if (NumSrc < 2 || RegEvery < 1) begin : g_param_err
    $error("prim_max_tree_pipe: NumSrc must be >= 2 and RegEvery >= 1");
  end

  // Nodes use heap numbering: root is 1, children of n are 2n and 2n+1, leaves start at NumLeaves.
  function automatic int node_level(input int n);
    int l;
    l = 0;
    for (int j = 1; j <= NumLevels; j++) begin
      l = (n >= (1 << j)) ? j : l;
    end
    return l;
  endfunction

  function automatic int bound_level(input int s);
    int b;
    b = NumLevels - s * RegEvery;
    return (b < 0) ? 0 : b;
  endfunction

  // Stage whose register sits at this level, 0 if the level is purely combinational.
  function automatic int stage_at(input int lvl);
    int r;
    r = 0;
    for (int s = 1; s <= NumStages; s++) begin
      r = (bound_level(s) == lvl) ? s : r;
    end
    return r;
  endfunction

  // Stage whose front-end logic computes nodes at this level.
  function automatic int stage_for(input int lvl);
    int r;
    r = NumStages;
    for (int s = NumStages; s >= 1; s--) begin
      r = (bound_level(s) <= lvl) ? s : r;
    end
    return r;
  endfunction

  logic                w_q [NumNodes];
  logic [Width-1:0]    w_v [NumNodes];
  logic [SrcWidth-1:0] w_i [NumNodes];
  logic                r_q [NumNodes];
  logic [Width-1:0]    r_v [NumNodes];
  logic [SrcWidth-1:0] r_i [NumNodes];
  logic                r_mode [NumStages+1];
  logic [NumStages:1]  r_sv;
  logic [NumStages:0]  w_rdy;
  logic [NumStages:1]  w_up;
  logic [NumStages:0]  w_load;

  // Comparison tree: leaves qualify against the threshold, internal nodes pick the better child.
  always_comb begin
    logic                q0, q1, md, sel;
    logic [Width-1:0]    v0, v1;
    logic [SrcWidth-1:0] i0, i1;
    int                  lvl, cs, st;
    q0  = 1'b0;
    q1  = 1'b0;
    md  = 1'b0;
    sel = 1'b0;
    v0  = {Width{1'b0}};
    v1  = {Width{1'b0}};
    i0  = {SrcWidth{1'b0}};
    i1  = {SrcWidth{1'b0}};
    lvl = 0;
    cs  = 0;
    st  = 0;
    for (int n = 0; n < NumNodes; n++) begin
      w_q[n] = 1'b0;
      w_v[n] = {Width{1'b0}};
      w_i[n] = {SrcWidth{1'b0}};
    end
    for (int k = 0; k < NumSrc; k++) begin
      w_v[NumLeaves+k] = values_i[k*Width +: Width];
      w_i[NumLeaves+k] = SrcWidth'(k);
      w_q[NumLeaves+k] = valid_i[k] & (min_mode_i ? (values_i[k*Width +: Width] < threshold_i)
                                                  : (values_i[k*Width +: Width] > threshold_i));
    end
    for (int n = NumLeaves - 1; n >= 1; n--) begin
      lvl = node_level(n);
      cs  = stage_at(lvl + 1);
      st  = stage_for(lvl);
      if (cs != 0) begin
        q0 = r_q[2*n];   v0 = r_v[2*n];   i0 = r_i[2*n];
        q1 = r_q[2*n+1]; v1 = r_v[2*n+1]; i1 = r_i[2*n+1];
      end else begin
        q0 = w_q[2*n];   v0 = w_v[2*n];   i0 = w_i[2*n];
        q1 = w_q[2*n+1]; v1 = w_v[2*n+1]; i1 = w_i[2*n+1];
      end
      md  = (st == 1) ? min_mode_i : r_mode[st-1];
      sel = (q1 & ~q0) | (q1 & q0 & (md ? (v1 < v0) : (v1 > v0)));
      w_q[n] = sel ? q1 : q0;
      w_v[n] = sel ? v1 : v0;
      w_i[n] = sel ? i1 : i0;
    end
  end

  // Ready chain runs back from the consumer; an empty stage is always ready.
  always_comb begin
    w_rdy  = {(NumStages+1){1'b0}};
    w_up   = {NumStages{1'b0}};
    w_load = {(NumStages+1){1'b0}};
    w_rdy[NumStages] = out_ready_i;
    for (int s = NumStages; s >= 1; s--) begin
      w_rdy[s-1] = ~r_sv[s] | w_rdy[s];
    end
    w_up[1] = in_valid_i;
    for (int s = 2; s <= NumStages; s++) begin
      w_up[s] = r_sv[s-1];
    end
    for (int s = 1; s <= NumStages; s++) begin
      w_load[s] = w_rdy[s-1] & w_up[s];
    end
  end

  // Stage valid bits, per-beat mode and boundary-level node registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sv <= {NumStages{1'b0}};
      for (int s = 0; s <= NumStages; s++) begin
        r_mode[s] <= 1'b0;
      end
      for (int n = 0; n < NumNodes; n++) begin
        r_q[n] <= 1'b0;
        r_v[n] <= {Width{1'b0}};
        r_i[n] <= {SrcWidth{1'b0}};
      end
    end else begin
      for (int s = 1; s <= NumStages; s++) begin
        if (w_rdy[s-1]) begin
          r_sv[s] <= w_up[s];
        end
        if (w_load[s]) begin
          r_mode[s] <= (s == 1) ? min_mode_i : r_mode[s-1];
        end
      end
      for (int n = 1; n < NumLeaves; n++) begin
        if (w_load[stage_at(node_level(n))]) begin
          r_q[n] <= w_q[n];
          r_v[n] <= w_v[n];
          r_i[n] <= w_i[n];
        end
      end
    end
  end

  assign in_ready_o  = w_rdy[0];
  assign out_valid_o = r_sv[NumStages];
  assign max_value_o = r_v[1];
  assign max_idx_o   = r_i[1];
  assign max_valid_o = r_q[1];

endmodule

// File: tb/tb_prim_max_tree_pipe.sv
// Bench for prim_max_tree_pipe: four configurations share one stimulus stream and are
// compared against a linear-scan reference model through per-instance scoreboards.
module tb_prim_max_tree_pipe;

  typedef struct packed {
    logic [7:0] v;
    logic [4:0] i;
    logic       q;
  } res_t;

  localparam int NSRC [4] = '{5, 2, 32, 32};
  localparam int NSTG [4] = '{3, 1, 3, 1};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic         mode = 1'b0;
  logic [7:0]   thr = 8'd0;
  logic [255:0] vals = '0;
  logic [31:0]  vld = '0;

  logic [3:0]      ov, ir, mv;
  logic [3:0][7:0] mval;
  logic [3:0][4:0] midx;
  logic [2:0]      idx0;
  logic [0:0]      idx1;
  logic [4:0]      idx2, idx3;

  assign midx[0] = {2'b00, idx0};
  assign midx[1] = {4'b0000, idx1};
  assign midx[2] = idx2;
  assign midx[3] = idx3;

  int n_pass = 0;
  int n_total = 0;

  res_t fifo [4][64];
  int   wp [4];
  int   rp [4];
  logic held [4];
  res_t hv [4];

  always #5 clk = ~clk;

  prim_max_tree_pipe #(.NumSrc(5), .Width(8), .RegEvery(1)) u0 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(ir[0]),
    .values_i(vals[39:0]), .valid_i(vld[4:0]), .min_mode_i(mode), .threshold_i(thr),
    .out_valid_o(ov[0]), .out_ready_i(out_ready), .max_value_o(mval[0]),
    .max_idx_o(idx0), .max_valid_o(mv[0]));

  prim_max_tree_pipe #(.NumSrc(2), .Width(8), .RegEvery(1)) u1 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(ir[1]),
    .values_i(vals[15:0]), .valid_i(vld[1:0]), .min_mode_i(mode), .threshold_i(thr),
    .out_valid_o(ov[1]), .out_ready_i(out_ready), .max_value_o(mval[1]),
    .max_idx_o(idx1), .max_valid_o(mv[1]));

  prim_max_tree_pipe #(.NumSrc(32), .Width(8), .RegEvery(2)) u2 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(ir[2]),
    .values_i(vals), .valid_i(vld), .min_mode_i(mode), .threshold_i(thr),
    .out_valid_o(ov[2]), .out_ready_i(out_ready), .max_value_o(mval[2]),
    .max_idx_o(idx2), .max_valid_o(mv[2]));

  prim_max_tree_pipe #(.NumSrc(32), .Width(8), .RegEvery(5)) u3 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(ir[3]),
    .values_i(vals), .valid_i(vld), .min_mode_i(mode), .threshold_i(thr),
    .out_valid_o(ov[3]), .out_ready_i(out_ready), .max_value_o(mval[3]),
    .max_idx_o(idx3), .max_valid_o(mv[3]));

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
  endtask

  // Reference: linear scan, strictly better replaces, so ties keep the lowest index.
  function automatic res_t model(input int n, input logic [255:0] v, input logic [31:0] vl,
                                 input logic md, input logic [7:0] th);
    res_t r;
    logic [7:0] x;
    logic ok;
    r.v = v[7:0];
    r.i = 5'd0;
    r.q = 1'b0;
    for (int k = 0; k < n; k++) begin
      x  = v[8*k +: 8];
      ok = vl[k] && (md ? (x < th) : (x > th));
      if (ok && (!r.q || (md ? (x < r.v) : (x > r.v)))) begin
        r.v = x;
        r.i = 5'(k);
        r.q = 1'b1;
      end
    end
    return r;
  endfunction

  // Scoreboard monitor, sampling 1 time unit before each rising edge.
  always begin : mon
    res_t got;
    @(negedge clk);
    #4;
    if (rst) begin
      for (int d = 0; d < 4; d++) begin
        wp[d] = 0;
        rp[d] = 0;
        held[d] = 1'b0;
      end
    end else begin
      for (int d = 0; d < 4; d++) begin
        got = {mval[d], midx[d], mv[d]};
        if (held[d]) begin
          chk("hold_valid", d, 32'(ov[d]), 32'd1);
          chk("hold_data", d, 32'(got), 32'(hv[d]));
        end
        chk("in_ready", d, 32'(ir[d]), 32'(!(((wp[d] - rp[d]) == NSTG[d]) && !out_ready)));
        chk("spurious", d, 32'(ov[d] && (wp[d] == rp[d])), 32'd0);
        if (ov[d] && (wp[d] != rp[d])) begin
          chk("result", d, 32'(got), 32'(fifo[d][rp[d] % 64]));
          if (out_ready) rp[d]++;
        end
        if (in_valid && ir[d]) begin
          fifo[d][wp[d] % 64] = model(NSRC[d], vals, vld, mode, thr);
          wp[d]++;
        end
        held[d] = ov[d] && !out_ready;
        hv[d] = got;
      end
    end
  end

  task automatic rand_beat();
    for (int i = 0; i < 32; i++) begin
      vals[8*i +: 8] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
    end
    vld  = $urandom | $urandom;
    mode = 1'($urandom_range(0, 1));
    thr  = 8'($urandom_range(0, 15));
  endtask

  task automatic send_dir(input logic [39:0] v5, input logic [4:0] vl, input logic md,
                          input logic [7:0] th, input logic [7:0] ev, input logic [4:0] ei,
                          input logic em);
    int lat [4];
    logic [7:0] gv;
    logic [4:0] gi;
    logic gm;
    gv = 8'd0;
    gi = 5'd0;
    gm = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) vals[32*i +: 32] = $urandom;
    vals[39:0] = v5;
    vld = $urandom;
    vld[4:0] = vl;
    mode = md;
    thr = th;
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int d = 0; d < 4; d++) lat[d] = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) in_valid = 1'b0;
      for (int d = 0; d < 4; d++) begin
        if (lat[d] == 0 && ov[d]) begin
          lat[d] = k;
          if (d == 0) begin
            gv = mval[0];
            gi = midx[0];
            gm = mv[0];
          end
        end
      end
    end
    for (int d = 0; d < 4; d++) chk("latency", d, 32'(lat[d]), 32'(NSTG[d]));
    chk("dir_value", 0, 32'(gv), 32'(ev));
    chk("dir_idx", 0, 32'(gi), 32'(ei));
    chk("dir_valid", 0, 32'(gm), 32'(em));
  endtask

  initial begin
    // Reset held with toggling inputs.
    repeat (4) begin
      @(negedge clk);
      rand_beat();
      in_valid = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      for (int d = 0; d < 4; d++) begin
        chk("rst_out_valid", d, 32'(ov[d]), 32'd0);
        chk("rst_value", d, 32'(mval[d]), 32'd0);
        chk("rst_idx", d, 32'(midx[d]), 32'd0);
        chk("rst_max_valid", d, 32'(mv[d]), 32'd0);
        chk("rst_in_ready", d, 32'(ir[d]), 32'd1);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;

    send_dir({8'd7, 8'd1, 8'd9, 8'd9, 8'd3}, 5'b11111, 1'b0, 8'd0, 8'd9, 5'd1, 1'b1);
    send_dir({8'd7, 8'd1, 8'd9, 8'd9, 8'd3}, 5'b11111, 1'b1, 8'd8, 8'd1, 5'd3, 1'b1);
    send_dir({8'd7, 8'd1, 8'd9, 8'd9, 8'd3}, 5'b11111, 1'b1, 8'd1, 8'd3, 5'd0, 1'b0);
    send_dir({8'd0, 8'd0, 8'd4, 8'd200, 8'd5}, 5'b11101, 1'b0, 8'd4, 8'd5, 5'd0, 1'b1);

    // Back-to-back stream: every instance must emit once per cycle once filled.
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
        if (k >= NSTG[d]) chk("stream_out_valid", d, 32'(ov[d]), 32'd1);
      end
      rand_beat();
      in_valid = 1'b1;
      out_ready = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);

    // Random backpressure.
    repeat (300) begin
      @(negedge clk);
      rand_beat();
      in_valid = ($urandom_range(0, 9) < 7);
      out_ready = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (8) @(negedge clk);
    for (int d = 0; d < 4; d++) chk("drain", d, 32'(wp[d] - rp[d]), 32'd0);

    // Mid-stream reset with three beats in flight.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rand_beat();
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("full_out_valid", 0, 32'(ov[0]), 32'd1);
    chk("full_in_ready", 0, 32'(ir[0]), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    for (int d = 0; d < 4; d++) chk("rst_async", d, 32'(ov[d]), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (10) begin
      @(negedge clk);
      for (int d = 0; d < 4; d++) chk("stale", d, 32'(ov[d]), 32'd0);
    end

    send_dir({8'd7, 8'd1, 8'd9, 8'd9, 8'd3}, 5'b11111, 1'b0, 8'd0, 8'd9, 5'd1, 1'b1);
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
